// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexed driver for NUM_DIGITS common-anode
// seven-segment digits on a shared, active-low segment bus.
// Double-buffered display value (pending -> active at frame wrap), one digit
// per PRESCALE-cycle slot, anodes/segments blanked for BLANK_CYCLES at slot start.
// Optional: define SEVEN_SEG_LZB_EN for leading-zero blanking.

// Per-digit segment pattern: hex decode, dp, enable and blanking.
module seven_seg_digit (
  input  logic [3:0] nib,
  input  logic       dp,
  input  logic       en,
  input  logic       blank,
  output logic [7:0] seg
);
  logic [6:0] h7;

  // Hex to {g..a}, active low; blanked digits keep dp
  always_comb begin
    unique case (nib)
      4'h0: h7 = 7'h40;
      4'h1: h7 = 7'h79;
      4'h2: h7 = 7'h24;
      4'h3: h7 = 7'h30;
      4'h4: h7 = 7'h19;
      4'h5: h7 = 7'h12;
      4'h6: h7 = 7'h02;
      4'h7: h7 = 7'h78;
      4'h8: h7 = 7'h00;
      4'h9: h7 = 7'h18;
      4'hA: h7 = 7'h08;
      4'hB: h7 = 7'h03;
      4'hC: h7 = 7'h46;
      4'hD: h7 = 7'h21;
      4'hE: h7 = 7'h06;
      default: h7 = 7'h0E;
    endcase
    if (blank) h7 = 7'h7F;
    seg = en ? {~dp, h7} : 8'hFF;
  end
endmodule

module seven_seg_scan #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    load,
  output logic                    frame_done,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              seg
);
  localparam int KW = $clog2(PRESCALE);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [KW-1:0] K_LAST  = KW'(PRESCALE - 1);
  localparam logic [KW-1:0] K_BLANK = KW'(BLANK_CYCLES);
  localparam logic [IW-1:0] I_LAST  = IW'(NUM_DIGITS - 1);

  logic [KW-1:0] k;
  logic [IW-1:0] i;
  logic          k_wrap, f_wrap;

  logic [NUM_DIGITS-1:0][3:0] pend_val, act_val;
  logic [NUM_DIGITS-1:0]      pend_dp, pend_en, act_dp, act_en;
  logic                       pend_dirty;

  logic [NUM_DIGITS-1:0][7:0] dseg;
  logic [NUM_DIGITS-1:0]      lzb;
  logic [NUM_DIGITS-1:0]      an_nxt;
  logic [7:0]                 seg_nxt;

  assign k_wrap = (k == K_LAST);
  assign f_wrap = k_wrap && (i == I_LAST);

  // Slot counter and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= '0;
      i <= '0;
    end else if (k_wrap) begin
      k <= '0;
      i <= (i == I_LAST) ? '0 : i + 1'b1;
    end else begin
      k <= k + 1'b1;
    end
  end

  // Double buffer: a load on the wrap edge stays dirty for the next wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_en    <= '0;
      pend_dirty <= 1'b0;
      act_val    <= '0;
      act_dp     <= '0;
      act_en     <= '0;
    end else begin
      if (f_wrap && pend_dirty) begin
        act_val <= pend_val;
        act_dp  <= pend_dp;
        act_en  <= pend_en;
      end
      if (load) begin
        pend_val <= value;
        pend_dp  <= dp;
        pend_en  <= digit_en;
      end
      pend_dirty <= load ? 1'b1 : (f_wrap ? 1'b0 : pend_dirty);
    end
  end

`ifdef SEVEN_SEG_LZB_EN
  // hz[g]: every enabled digit above g holds a zero nibble
  logic [NUM_DIGITS-1:1] hz;
  assign hz[NUM_DIGITS-1] = 1'b1;
  for (genvar g = 1; g < NUM_DIGITS - 1; g++) begin : g_hz
    assign hz[g] = hz[g+1] & (~act_en[g+1] | (act_val[g+1] == 4'h0));
  end
  assign lzb[0] = 1'b0;
  for (genvar g = 1; g < NUM_DIGITS; g++) begin : g_lzb
    assign lzb[g] = hz[g] & (act_val[g] == 4'h0);
  end
`else
  assign lzb = '0;
`endif

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    seven_seg_digit u_dig (
      .nib   (act_val[g]),
      .dp    (act_dp[g]),
      .en    (act_en[g]),
      .blank (lzb[g]),
      .seg   (dseg[g])
    );
  end

  // Select current digit; dark during the anti-ghost window
  always_comb begin
    an_nxt  = '1;
    seg_nxt = 8'hFF;
    if (k >= K_BLANK) begin
      an_nxt[i] = ~act_en[i];
      seg_nxt   = dseg[i];
    end
  end

  // Registered pin drive; an and seg always change together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an         <= '1;
      seg        <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      an         <= an_nxt;
      seg        <= seg_nxt;
      frame_done <= f_wrap;
    end
  end
endmodule
